clock_mode_ctrl: RTL and testbench

Top-level mode sequencer for the digital clock.
- Owns the user buttons and decides which setting engine (time-set or alarm-set) receives enable and button pulses.
- Freezes timekeeping while the time is being edited.
- Detects alarm match and runs the ringing/snooze/auto-off sequence that drives the buzzer.

---
 rtl/clock_mode_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: top-level mode sequencer for the digital clock.
// Routes the user buttons to the time-set or alarm-set engine, freezes the
// timekeeper while the time is edited, and runs the alarm ring/snooze/auto-off
// sequence that drives the buzzer.
module clock_mode_ctrl #(
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_SECS = 300,
   parameter int CNT_W       = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        set_btn,
   input  logic        mode_btn,
   input  logic        inc_btn,
   input  logic        sec_tick,
   input  logic [12:0] cur_time,
   input  logic [12:0] alm_time,
   input  logic        alarm_on,
   input  logic        time_ack,
   input  logic        alarm_ack,
   output logic        set_time_en,
   output logic        set_alarm_en,
   output logic        mode_pulse,
   output logic        inc_pulse,
   output logic        clock_run,
   output logic        buzzer,
   output logic        snooze_active,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_SET_TIME  = 2'd1,
      ST_SET_ALARM = 2'd2,
      ST_RINGING   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECS) - CNT_ONE;
   localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SECS);

   state_t           state_r;
   state_t           state_s;
   logic             set_q_r;
   logic             mode_q_r;
   logic             inc_q_r;
   logic             match_q_r;
   logic             mode_pulse_r;
   logic             inc_pulse_r;
   logic             snooze_active_r;
   logic             snooze_pending_r;
   logic [CNT_W-1:0] ring_cnt_r;
   logic [CNT_W-1:0] snooze_cnt_r;

   logic             set_evt_s;
   logic             mode_evt_s;
   logic             inc_evt_s;
   logic             match_s;
   logic             trig_s;
   logic             in_set_s;
   logic             ring_start_s;
   logic             alarm_entry_s;
   logic             snooze_go_s;

   // Press events, alarm match edge and transition qualifiers
   always_comb begin
      set_evt_s     = set_btn & ~set_q_r;
      mode_evt_s    = mode_btn & ~mode_q_r;
      inc_evt_s     = inc_btn & ~inc_q_r;
      match_s       = alarm_on & (cur_time == alm_time);
      trig_s        = match_s & ~match_q_r;
      in_set_s      = (state_r == ST_SET_TIME) || (state_r == ST_SET_ALARM);
      ring_start_s  = (state_r == ST_RUN) && (state_s == ST_RINGING);
      alarm_entry_s = (state_r != ST_SET_ALARM) && (state_s == ST_SET_ALARM);
      snooze_go_s   = (state_r == ST_RINGING) && !mode_evt_s && inc_evt_s;
   end

   // Button / match history registers and forwarded press pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         set_q_r      <= 1'b0;
         mode_q_r     <= 1'b0;
         inc_q_r      <= 1'b0;
         match_q_r    <= 1'b0;
         mode_pulse_r <= 1'b0;
         inc_pulse_r  <= 1'b0;
      end else begin
         set_q_r      <= set_btn;
         mode_q_r     <= mode_btn;
         inc_q_r      <= inc_btn;
         match_q_r    <= match_s;
         mode_pulse_r <= mode_evt_s & in_set_s;
         inc_pulse_r  <= inc_evt_s & in_set_s;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic; a ring request beats a simultaneous set press
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_RUN: begin
            if (trig_s || snooze_pending_r) state_s = ST_RINGING;
            else if (set_evt_s)             state_s = ST_SET_TIME;
            else                            state_s = ST_RUN;
         end
         ST_SET_TIME: begin
            if (time_ack)       state_s = ST_RUN;
            else if (set_evt_s) state_s = ST_SET_ALARM;
            else                state_s = ST_SET_TIME;
         end
         ST_SET_ALARM: begin
            if (alarm_ack)      state_s = ST_RUN;
            else if (set_evt_s) state_s = ST_RUN;
            else                state_s = ST_SET_ALARM;
         end
         ST_RINGING: begin
            if (mode_evt_s || inc_evt_s)                 state_s = ST_RUN;
            else if (sec_tick && ring_cnt_r == RING_LAST) state_s = ST_RUN;
            else                                         state_s = ST_RINGING;
         end
         default: state_s = ST_RUN;
      endcase
   end

   // FSM output decode
   always_comb begin
      set_time_en   = 1'b0;
      set_alarm_en  = 1'b0;
      clock_run     = 1'b1;
      buzzer        = 1'b0;
      case (state_r)
         ST_RUN:       clock_run    = 1'b1;
         ST_SET_TIME: begin
            set_time_en = 1'b1;
            clock_run   = 1'b0;
         end
         ST_SET_ALARM: set_alarm_en = 1'b1;
         ST_RINGING:   buzzer       = 1'b1;
         default:      clock_run    = 1'b1;
      endcase
      mode_pulse    = mode_pulse_r;
      inc_pulse     = inc_pulse_r;
      snooze_active = snooze_active_r;
      state         = state_r;
   end

   // Ring duration counter: cleared on ring start, counts seconds while ringing
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ring_cnt_r <= CNT_ZERO;
      end else if (ring_start_s) begin
         ring_cnt_r <= CNT_ZERO;
      end else if (state_r == ST_RINGING && sec_tick && !mode_evt_s && !inc_evt_s) begin
         ring_cnt_r <= ring_cnt_r + CNT_ONE;
      end else begin
         ring_cnt_r <= ring_cnt_r;
      end
   end

   // Snooze countdown; expiry leaves a pending request that RUN serves
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snooze_active_r  <= 1'b0;
         snooze_pending_r <= 1'b0;
         snooze_cnt_r     <= CNT_ZERO;
      end else if (!alarm_on || ring_start_s || alarm_entry_s) begin
         snooze_active_r  <= 1'b0;
         snooze_pending_r <= 1'b0;
         snooze_cnt_r     <= snooze_cnt_r;
      end else if (snooze_go_s) begin
         snooze_active_r  <= 1'b1;
         snooze_pending_r <= 1'b0;
         snooze_cnt_r     <= SNOOZE_LOAD;
      end else if (snooze_active_r && sec_tick) begin
         if (snooze_cnt_r == CNT_ONE) begin
            snooze_active_r  <= 1'b0;
            snooze_pending_r <= 1'b1;
            snooze_cnt_r     <= CNT_ZERO;
         end else begin
            snooze_active_r  <= 1'b1;
            snooze_pending_r <= snooze_pending_r;
            snooze_cnt_r     <= snooze_cnt_r - CNT_ONE;
         end
      end else begin
         snooze_active_r  <= snooze_active_r;
         snooze_pending_r <= snooze_pending_r;
         snooze_cnt_r     <= snooze_cnt_r;
      end
   end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed self-checking bench for clock_mode_ctrl.
module tb_clock_mode_ctrl;

   logic        clk;
   logic        rst;
   logic        set_btn, mode_btn, inc_btn, sec_tick;
   logic [12:0] cur_time, alm_time;
   logic        alarm_on, time_ack, alarm_ack;
   logic        set_time_en, set_alarm_en, mode_pulse, inc_pulse;
   logic        clock_run, buzzer, snooze_active;
   logic [1:0]  state;

   int n_checks;
   int n_errors;
   int mode_seen;
   int inc_seen;
   logic first_mode;

   // BCD {hl,hr,ml,mr}
   localparam logic [12:0] T0729 = {2'd0, 4'd7, 3'd2, 4'd9};
   localparam logic [12:0] T0730 = {2'd0, 4'd7, 3'd3, 4'd0};
   localparam logic [12:0] T0731 = {2'd0, 4'd7, 3'd3, 4'd1};

   clock_mode_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .set_btn       (set_btn),
      .mode_btn      (mode_btn),
      .inc_btn       (inc_btn),
      .sec_tick      (sec_tick),
      .cur_time      (cur_time),
      .alm_time      (alm_time),
      .alarm_on      (alarm_on),
      .time_ack      (time_ack),
      .alarm_ack     (alarm_ack),
      .set_time_en   (set_time_en),
      .set_alarm_en  (set_alarm_en),
      .mode_pulse    (mode_pulse),
      .inc_pulse     (inc_pulse),
      .clock_run     (clock_run),
      .buzzer        (buzzer),
      .snooze_active (snooze_active),
      .state         (state)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // which: 0=set 1=mode 2=inc; holds n cycles, then 3 idle, counting forwarded pulses
   task automatic hold_btn(input int which, input int n);
      mode_seen = 0;
      inc_seen  = 0;
      case (which)
         0:       set_btn  = 1'b1;
         1:       mode_btn = 1'b1;
         default: inc_btn  = 1'b1;
      endcase
      for (int i = 0; i < n + 3; i++) begin
         if (i == n) begin
            set_btn  = 1'b0;
            mode_btn = 1'b0;
            inc_btn  = 1'b0;
         end
         cyc(1);
         if (i == 0) first_mode = mode_pulse;
         if (mode_pulse) mode_seen++;
         if (inc_pulse)  inc_seen++;
      end
   endtask

   task automatic do_ticks(input int n);
      repeat (n) begin
         sec_tick = 1'b1;
         cyc(1);
         sec_tick = 1'b0;
         cyc(1);
      end
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      rst = 1'b0;
      set_btn = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0; sec_tick = 1'b0;
      cur_time = T0729; alm_time = T0730;
      alarm_on = 1'b0; time_ack = 1'b0; alarm_ack = 1'b0;
      cyc(3);
      rst = 1'b1;
      cyc(10);

      // reset state
      check_val("rst_state", 32'(state), 32'd0);
      check_val("rst_clock_run", 32'(clock_run), 32'd1);
      check_val("rst_buzzer", 32'(buzzer), 32'd0);
      check_val("rst_set_time_en", 32'(set_time_en), 32'd0);
      check_val("rst_set_alarm_en", 32'(set_alarm_en), 32'd0);
      check_val("rst_snooze", 32'(snooze_active), 32'd0);

      // acks outside their SET state are ignored
      time_ack = 1'b1; alarm_ack = 1'b1;
      cyc(1);
      check_val("ack_in_run", 32'(state), 32'd0);
      time_ack = 1'b0; alarm_ack = 1'b0;

      // held set: exactly one transition
      hold_btn(0, 5);
      check_val("set_held_state", 32'(state), 32'd1);
      check_val("set_time_clock_run", 32'(clock_run), 32'd0);
      check_val("set_time_en", 32'(set_time_en), 32'd1);
      hold_btn(1, 3);
      check_val("mode_pulse_count", 32'(mode_seen), 32'd1);
      check_val("mode_pulse_first", 32'(first_mode), 32'd1);
      check_val("mode_keeps_state", 32'(state), 32'd1);
      hold_btn(2, 2);
      check_val("inc_pulse_count", 32'(inc_seen), 32'd1);
      time_ack = 1'b1;
      cyc(1);
      check_val("time_ack_state", 32'(state), 32'd0);
      check_val("time_ack_clock_run", 32'(clock_run), 32'd1);
      time_ack = 1'b0;
      cyc(2);

      // set cycles 0 -> 1 -> 2 -> 0
      hold_btn(0, 1);
      check_val("cyc_state1", 32'(state), 32'd1);
      check_val("cyc_s1_alarm_en", 32'(set_alarm_en), 32'd0);
      hold_btn(0, 1);
      check_val("cyc_state2", 32'(state), 32'd2);
      check_val("cyc_s2_alarm_en", 32'(set_alarm_en), 32'd1);
      check_val("cyc_s2_time_en", 32'(set_time_en), 32'd0);
      check_val("cyc_s2_clock_run", 32'(clock_run), 32'd1);
      hold_btn(0, 1);
      check_val("cyc_state0", 32'(state), 32'd0);
      check_val("cyc_s0_alarm_en", 32'(set_alarm_en), 32'd0);
      hold_btn(1, 3);
      check_val("run_no_mode_pulse", 32'(mode_seen), 32'd0);
      hold_btn(2, 3);
      check_val("run_no_inc_pulse", 32'(inc_seen), 32'd0);

      // alarm_ack leaves SET_ALARM
      hold_btn(0, 1);
      hold_btn(0, 1);
      alarm_ack = 1'b1;
      cyc(1);
      check_val("alarm_ack_state", 32'(state), 32'd0);
      alarm_ack = 1'b0;
      cyc(2);

      // alarm match and auto-off after 60 ticks
      alarm_on = 1'b1;
      cyc(2);
      check_val("pre_match_buzzer", 32'(buzzer), 32'd0);
      cur_time = T0730;
      cyc(1);
      check_val("match_buzzer", 32'(buzzer), 32'd1);
      check_val("match_state", 32'(state), 32'd3);
      do_ticks(59);
      check_val("ring_59_buzzer", 32'(buzzer), 32'd1);
      do_ticks(1);
      check_val("ring_60_buzzer", 32'(buzzer), 32'd0);
      check_val("ring_60_state", 32'(state), 32'd0);
      cyc(20);
      check_val("no_retrigger", 32'(buzzer), 32'd0);

      // snooze and re-ring after 300 ticks
      cur_time = T0731;
      cyc(2);
      cur_time = T0730;
      cyc(1);
      check_val("ring2_buzzer", 32'(buzzer), 32'd1);
      hold_btn(2, 1);
      check_val("snooze_buzzer", 32'(buzzer), 32'd0);
      check_val("snooze_active", 32'(snooze_active), 32'd1);
      do_ticks(299);
      check_val("snooze_299_buzzer", 32'(buzzer), 32'd0);
      check_val("snooze_299_active", 32'(snooze_active), 32'd1);
      do_ticks(1);
      check_val("rering_buzzer", 32'(buzzer), 32'd1);
      check_val("rering_snooze", 32'(snooze_active), 32'd0);
      hold_btn(1, 1);
      check_val("dismiss_buzzer", 32'(buzzer), 32'd0);
      check_val("dismiss_snooze", 32'(snooze_active), 32'd0);

      // ring trigger beats set press; set ignored while ringing
      cur_time = T0731;
      cyc(2);
      cur_time = T0730;
      set_btn  = 1'b1;
      cyc(1);
      set_btn  = 1'b0;
      check_val("ring_vs_set", 32'(state), 32'd3);
      cyc(1);
      hold_btn(0, 2);
      check_val("set_ignored_ringing", 32'(state), 32'd3);
      hold_btn(2, 1);
      check_val("snooze2_active", 32'(snooze_active), 32'd1);
      do_ticks(10);
      alarm_on = 1'b0;
      cyc(1);
      check_val("alarm_off_snooze", 32'(snooze_active), 32'd0);
      do_ticks(300);
      check_val("alarm_off_no_ring", 32'(buzzer), 32'd0);
      check_val("alarm_off_state", 32'(state), 32'd0);

      // async reset mid-ring
      cur_time = T0731;
      alarm_on = 1'b1;
      cyc(2);
      cur_time = T0730;
      cyc(1);
      check_val("pre_rst_buzzer", 32'(buzzer), 32'd1);
      rst = 1'b0;
      #1;
      check_val("midring_rst_buzzer", 32'(buzzer), 32'd0);
      check_val("midring_rst_state", 32'(state), 32'd0);
      check_val("midring_rst_clock_run", 32'(clock_run), 32'd1);
      cyc(2);
      rst = 1'b1;
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
